// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU for the Y86 execute stage.
//
// Stage 1 registers the offered operation. Stage 2 registers the computed
// result, signed overflow and illegal-opcode flag. A result retires on
// out_valid & out_ready, and it updates the condition codes (ZF/SF/OF)
// when it was issued with set_cc and the opcode was legal. Latency is two
// cycles, throughput is one operation per cycle, and there is no skid
// buffer, so in_ready is combinational from out_ready.
//
// Optional feature macro: ALU_SHIFT_EN
//   defined   : op 4 SHL, op 5 SHR (logical), op 6 SAR (arithmetic), op 7 illegal
//   undefined : ops 4-7 illegal, no shifter is built
//
// Parameters
//   WIDTH    operand/result width, power of two from 8 to 64
//   SHAMT_W  shift-amount width, taken from the low bits of b
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   flush                  clears both pipeline valid bits at the edge
//   in_valid/in_ready      input handshake
//   in_op, in_a, in_b      opcode and operands
//   in_set_cc              the operation updates the CC when it retires
//   out_valid/out_ready    output handshake
//   out_result, out_of     result and its signed overflow
//   out_err                illegal opcode (result forced to 0)
//   cc_zf, cc_sf, cc_of    architectural condition codes

module alu_pipe #(
   parameter int WIDTH   = 64,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_of,
   output logic             out_err,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of
);

   if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
      $error("alu_pipe: WIDTH must be a power of two from 8 to 64");
   end
   if (SHAMT_W != $clog2(WIDTH)) begin : g_bad_shamt
      $error("alu_pipe: SHAMT_W must equal clog2(WIDTH)");
   end

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
`ifdef ALU_SHIFT_EN
   localparam logic [2:0] OP_SHL = 3'd4;
   localparam logic [2:0] OP_SHR = 3'd5;
   localparam logic [2:0] OP_SAR = 3'd6;
`endif

   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_set_cc;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_of;
   logic             s2_err;
   logic             s2_set_cc;

   logic             s1_adv;
   logic             s2_adv;
   logic             retire;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_of;
   logic             alu_err;

   assign s2_adv   = !s2_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign retire   = s2_valid && out_ready;

   assign sum  = s1_a + s1_b;
   assign diff = s1_a - s1_b;

   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      alu_err = 1'b0;
      case (s1_op)
         OP_ADD: begin
            alu_res = sum;
            alu_of  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_of  = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_AND: alu_res = s1_a & s1_b;
         OP_XOR: alu_res = s1_a ^ s1_b;
`ifdef ALU_SHIFT_EN
         OP_SHL: alu_res = s1_a << s1_b[SHAMT_W-1:0];
         OP_SHR: alu_res = s1_a >> s1_b[SHAMT_W-1:0];
         OP_SAR: alu_res = $unsigned($signed(s1_a) >>> s1_b[SHAMT_W-1:0]);
`endif
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_op      <= '0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_set_cc  <= 1'b0;
         s2_valid   <= 1'b0;
         s2_result  <= '0;
         s2_of      <= 1'b0;
         s2_err     <= 1'b0;
         s2_set_cc  <= 1'b0;
         cc_zf      <= 1'b1;
         cc_sf      <= 1'b0;
         cc_of      <= 1'b0;
      end else begin
         // Data registers only load with a valid operation, so a bubble
         // passing through leaves the last result in place.
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_result <= alu_res;
               s2_of     <= alu_of;
               s2_err    <= alu_err;
               s2_set_cc <= s1_set_cc;
            end
         end
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op     <= in_op;
               s1_a      <= in_a;
               s1_b      <= in_b;
               s1_set_cc <= in_set_cc;
            end
         end
         if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
         end
         // A result retiring in the flush cycle still commits its CC.
         if (retire && s2_set_cc && !s2_err) begin
            cc_zf <= (s2_result == '0);
            cc_sf <= s2_result[WIDTH-1];
            cc_of <= s2_of;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_result = s2_result;
   assign out_of     = s2_of;
   assign out_err    = s2_err;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 64-bit instance
   logic        reset, flush, in_valid, in_ready, in_set_cc;
   logic [2:0]  in_op;
   logic [63:0] in_a, in_b, out_result;
   logic        out_valid, out_ready, out_of, out_err, cc_zf, cc_sf, cc_of;

   // 8-bit instance
   logic        reset8, flush8, in_valid8, in_ready8, in_set_cc8;
   logic [2:0]  in_op8;
   logic [7:0]  in_a8, in_b8, out_result8;
   logic        out_valid8, out_ready8, out_of8, out_err8, cc_zf8, cc_sf8, cc_of8;

   alu_pipe #(.WIDTH(64)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_of(out_of), .out_err(out_err),
      .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset8), .flush(flush8),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
      .in_a(in_a8), .in_b(in_b8), .in_set_cc(in_set_cc8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
      .out_of(out_of8), .out_err(out_err8),
      .cc_zf(cc_zf8), .cc_sf(cc_sf8), .cc_of(cc_of8)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        set_cc;
      logic [63:0] res;
      logic        of;
      logic        err;
      logic        zf;
      logic        sf;
      logic        ccof;
   } vec_t;

   vec_t vecs[10];

   logic [63:0] expq[$];
   logic [63:0] prev_res;
   logic        prev_stall;
   logic        stall_seen;
   int          n, sent, got;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // {op, a, b, set_cc, result, of, err, ZF, SF, OF after retire}
      vecs[0] = '{3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{3'd1, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{3'd3, 64'hF0, 64'h0F, 1'b0, 64'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{3'd2, 64'hFF00, 64'h0FF0, 1'b1, 64'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{3'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{3'd7, 64'd1, 64'd1, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ALU_SHIFT_EN
      vecs[6] = '{3'd4, 64'd1, 64'd3, 1'b1, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{3'd6, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
      vecs[6] = '{3'd4, 64'd1, 64'd3, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{3'd5, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
      vecs[8] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{3'd1, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
      in_set_cc = 1'b0; out_ready = 1'b0;
      reset8 = 1'b1; flush8 = 1'b0; in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0;
      in_set_cc8 = 1'b0; out_ready8 = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      reset8 = 1'b0;
      #1;

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_of", out_of, 0);
      check("rst_out_err", out_err, 0);
      check("rst_cc_zf", cc_zf, 1);
      check("rst_cc_sf", cc_sf, 0);
      check("rst_cc_of", cc_of, 0);
      check("rst_in_ready", in_ready, 1);

      // Single operations, one at a time
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
         in_set_cc = vecs[i].set_cc;
         tick();
         in_valid = 1'b0;
         check("vec_not_early", out_valid, 0);
         tick();
         check("vec_out_valid", out_valid, 1);
         check("vec_result", out_result, vecs[i].res);
         check("vec_of", out_of, vecs[i].of);
         check("vec_err", out_err, vecs[i].err);
         tick();
         check("vec_drained", out_valid, 0);
         check("vec_cc_zf", cc_zf, vecs[i].zf);
         check("vec_cc_sf", cc_sf, vecs[i].sf);
         check("vec_cc_of", cc_of, vecs[i].ccof);
      end

      // Back-to-back stream of 8 ADDs, out_ready low in cycles 3-5
      n = 0; sent = 0; got = 0; prev_stall = 1'b0; prev_res = '0; stall_seen = 1'b0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (prev_stall) check("stall_hold", out_result, prev_res);
         out_ready = !(c >= 3 && c <= 5);
         in_valid = (sent < 8); in_op = 3'd0; in_a = 64'(sent); in_b = 64'd100; in_set_cc = 1'b0;
         #1;
         check("stream_in_ready", in_ready, !(n == 2 && !out_ready));
         if (!in_ready) stall_seen = 1'b1;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL stream_dup: got 0x%0h expected no result", out_result);
            end else begin
               check("stream_result", out_result, expq.pop_front());
            end
            got++;
            n--;
         end
         if (in_valid && in_ready) begin
            expq.push_back(64'(sent + 100));
            sent++;
            n++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res = out_result;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("stream_got", 64'(got), 8);
      check("stream_queue_empty", 64'(expq.size()), 0);
      check("stream_stall_seen", stall_seen, 1);
      check("stream_cc_hold", {cc_zf, cc_sf, cc_of}, 3'b010);

      // Flush with both stages full and an input offered, no retire
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'd0; in_a = 64'd1; in_b = 64'd1; in_set_cc = 1'b1;
      tick();
      in_op = 3'd1; in_a = 64'd0; in_b = 64'd1;
      tick();
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      in_op = 3'd0; in_a = 64'd0; in_b = 64'd0; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("flush_no_emit", out_valid, 0);
      end
      check("flush_cc_after", {cc_zf, cc_sf, cc_of}, 3'b010);

      // Flush coinciding with a retire: CC still commits
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'd1; in_a = 64'd3; in_b = 64'd3; in_set_cc = 1'b1;
      tick();
      in_op = 3'd0; in_a = 64'd1; in_b = 64'd1;
      tick();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ret_out_valid", out_valid, 0);
      check("flush_ret_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
      tick();
      check("flush_ret_no_emit", out_valid, 0);

      // WIDTH=8: wrap-around overflow
      out_ready8 = 1'b1;
      in_valid8 = 1'b1; in_op8 = 3'd0; in_a8 = 8'h80; in_b8 = 8'h80; in_set_cc8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      tick();
      check("w8_out_valid", out_valid8, 1);
      check("w8_result", out_result8, 8'h00);
      check("w8_of", out_of8, 1);
      tick();
      check("w8_cc", {cc_zf8, cc_sf8, cc_of8}, 3'b101);

      // WIDTH=8: reset while S2 holds a retiring result
      in_valid8 = 1'b1; in_a8 = 8'h40; in_b8 = 8'h40;
      tick();
      in_valid8 = 1'b0;
      tick();
      check("w8_s2_full", out_valid8, 1);
      check("w8_s2_result", out_result8, 8'h80);
      reset8 = 1'b1;
      tick();
      reset8 = 1'b0;
      check("w8_rst_out_valid", out_valid8, 0);
      check("w8_rst_cc", {cc_zf8, cc_sf8, cc_of8}, 3'b100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined integer ALU for the Y86 datapath, generalising the 64-bit four-operation execute ALU to any operand width with a valid/ready handshake, a flush input and an internal condition-code register (ZF/SF/OF). It sits in the Execute stage between the decode/execute pipeline register and the memory stage. It produces one result per cycle when not stalled, with a fixed two-cycle latency.

## Interface
- WIDTH, 64, operand/result width in bits; legal values are 8 to 64 and must be a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount width; used only with the shift feature.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of both pipeline stages.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage 1 can accept this cycle.
- in_op  in  3  operation code.
- in_a, in_b  in  WIDTH  operands.
- in_set_cc  in  1  the operation updates the condition codes when it retires.
- out_valid  out  1  stage 2 holds a result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result.
- out_of  out  1  signed overflow of this result.
- out_err  out  1  illegal opcode.
- cc_zf, cc_sf, cc_of  out  1 each  architectural condition codes.

## Operation
- Opcode meanings: 0 ADD (a+b), 1 SUB (a−b), 2 AND, 3 XOR. Opcodes 4–7 depend on the Configuration section.
- Stage 1 (S1) registers the op, operands and set_cc. Stage 2 (S2) registers the computed result, out_of and out_err.
- Arithmetic is modulo 2^WIDTH.
- out_of on ADD: the operand signs are equal and the result sign differs.
- out_of on SUB: the operand signs differ and the result sign differs from the sign of a.
- out_of is 0 for all other operations.
- Illegal opcode: out_result = 0, out_err = 1, out_of = 0; the condition codes never update.
- Retire event: out_valid & out_ready.
- On retire with set_cc = 1 and err = 0: cc_zf = (result == 0), cc_sf = result[WIDTH-1], cc_of = out_of.
- Condition codes hold their value on every other cycle.
- Advance rule: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. It is combinational from out_ready; there is no skid buffer.
- When s2_adv is high, S2 loads S1 (the valid bit follows s1_valid). When s1_adv is high, S1 loads the input (the valid bit follows in_valid).
- Data in a stalled stage holds stable. out_result, out_of and out_err must not change while out_valid & !out_ready.
- flush: both valid bits clear at the edge. An input offered in the same cycle is dropped, and a result retiring in the same cycle still updates the condition codes. The condition codes are not touched by flush.
- Precedence: reset > flush > normal operation.

## Timing
- Latency: an input accepted at edge N appears with out_valid = 1 after edge N+1 (visible in cycle N+1) when it is not stalled.
- Throughput is 1 operation per cycle with out_ready held high.
- Backpressure: with out_ready held low and both stages full, in_ready = 0. Releasing out_ready raises in_ready in the same cycle.
- Reset values: s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_of = 0, out_err = 0, cc_zf = 1, cc_sf = 0, cc_of = 0 (Y86 initial CC). in_ready = 1 in the first cycle after reset.
- Reset asserted mid-stream: all in-flight operations are discarded with no CC update, including a result retiring in the same cycle.

## Configuration
- ALU_SHIFT_EN defined: op 4 SHL (a << b[SHAMT_W-1:0]), op 5 SHR logical, op 6 SAR arithmetic; op 7 is illegal. Shifts give out_of = 0; ZF and SF update normally.
- ALU_SHIFT_EN undefined: ops 4–7 are all illegal and no shifter logic is instantiated.

## Test plan
- WIDTH=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with set_cc → result 0x8000_0000_0000_0000 two cycles later, out_of = 1; after retire ZF = 0, SF = 1, OF = 1.
- SUB 5 − 5 with set_cc, then XOR 0xF0 ^ 0x0F with set_cc = 0 → first retire gives ZF = 1, SF = 0, OF = 0; second gives result 0xFF and the CC stays unchanged.
- Back-to-back stream of 8 ADDs, out_ready low for cycles 3–5 → in_ready low while both stages are full, no result lost or duplicated, out_result stable during the stall, in-order results.
- Op 7 (and op 4 with ALU_SHIFT_EN undefined) with set_cc → out_err = 1, result 0, CC unchanged; with the macro defined, op 6 SAR 0x8000_0000_0000_0000 by 4 → 0xF800_0000_0000_0000.
- flush with S1 and S2 full and a new input offered → out_valid = 0 next cycle, the offered input is not emitted, the CC is unchanged unless a retire coincided.
- WIDTH=8: ADD 0x80 + 0x80 → result 0x00, out_of = 1, ZF = 1; reset asserted with S2 full → next cycle out_valid = 0, ZF = 1, SF = 0, OF = 0.
